lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit for the MEMORY stage, directly downstream of the ALU.
//  Takes the ALU effective address plus rs2_val and funct3, and checks alignment.
//  Runs one req/ack transaction on the data bus, then returns a lane-extracted,
//  sign/zero-extended load result to writeback. Stalls the core while busy.
// PARAMETERS
//  MAX_WAIT  255  bus cycles without mem_ack before the access aborts (1..255)
// PORTS
//  clk          in   1   core clock; all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   one-cycle pulse: access requested this cycle
//  is_load      in   1   decoded load
//  is_store     in   1   decoded store
//  funct3       in   3   RV32I width/sign field
//  address      in   32  effective address from ALU
//  store_data   in   32  rs2_val
//  mem_req      out  1   bus request, held until ack or timeout
//  mem_we       out  1   1 = write
//  mem_addr     out  32  {address[31:2],2'b00}
//  mem_wdata    out  32  lane-replicated store data
//  mem_wstrb    out  4   byte enables (0000 on loads)
//  mem_rdata    in   32  read data, valid with mem_ack
//  mem_ack      in   1   transfer complete this cycle
//  load_data    out  32  formatted load result
//  done         out  1   one-cycle completion pulse
//  fault        out  2   00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; valid with done
//  should_stall out  1   (state!=IDLE) | (start & accepted), combinational
// BEHAVIOUR
//  Reset: state IDLE. mem_req, mem_we, done = 0. mem_wstrb = 0. mem_addr, mem_wdata = 0.
//   load_data = 0, fault = 00, wait counter = 0. Asserting rst_n mid-access drops mem_req at once.
//  FSM IDLE -> ACCESS -> DONE -> IDLE; IDLE -> DONE directly on fault.
//  IDLE: start is accepted only if exactly one of is_load/is_store is set; otherwise it is ignored.
//   Legal funct3: load 0,1,2,4,5; store 0,1,2. Others -> DONE with fault=10.
//   Halfword needs address[0]==0; word needs address[1:0]==0. Else -> DONE with fault=01.
//   A faulting access never asserts mem_req.
//   Otherwise latch address, data, funct3 and type, and go to ACCESS.
//  ACCESS: mem_req=1. mem_addr, mem_we, mem_wdata and mem_wstrb stay stable until exit.
//   On mem_ack: a load captures formatted rdata into load_data. Go to DONE, fault=00.
//   The counter increments each cycle without ack; at MAX_WAIT go to DONE, fault=11.
//   ack in the same cycle the counter reaches MAX_WAIT: ack wins.
//  DONE: done=1 for exactly one cycle, then IDLE. The counter clears.
//  Latency: start in cycle 0, mem_req in cycles 1..k with ack in k, done in cycle k+1.
//   A fault gives done in cycle 1.
//  start while state!=IDLE is ignored. mem_ack outside ACCESS is ignored.
//  Store lanes (l = address[1:0]):
//   SB: wdata {4{d[7:0]}}, wstrb 0001<<l.
//   SH: wdata {2{d[15:0]}}, wstrb 0011<<(2*address[1]).
//   SW: wdata d, wstrb 1111.
//  Load extract:
//   LB/LBU: rdata[8l+:8], sign/zero-extended.
//   LH/LHU: rdata[16*address[1]+:16], sign/zero-extended.
//   LW: full word.
//  load_data holds its value until the next successful load. Stores and faults do not change it.
//  fault holds until the next accepted start.
// TESTING
//  1. LW at 0x100, ack in 1st req cycle, rdata 0xDEADBEEF -> mem_addr 0x100, done cycle 2, load_data 0xDEADBEEF, fault 00.
//  2. LB at 0x103, rdata 0x80FF1234 -> load_data 0xFFFFFF80. LBU same -> 0x00000080. LH at 0x102 -> 0xFFFF80FF.
//  3. SB at 0x201, data 0x000000AB -> mem_wdata 0xABABABAB, wstrb 0010, mem_we 1, mem_addr 0x200.
//  4. LW at 0x102 -> no mem_req, done cycle 1, fault 01. Load funct3=3 -> fault 10. should_stall high in the start cycle.
//  5. MAX_WAIT=4, no ack -> mem_req for 4 cycles, then dropped, fault 11. Repeat with ack on the 4th cycle -> fault 00.
//  6. Reset mid-ACCESS -> mem_req 0 immediately. A new start after release completes normally. start pulses during busy are ignored.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit for the MEMORY stage. Checks width/alignment of the ALU
// effective address, runs one req/ack transfer on the data bus and returns a
// lane-extracted, sign/zero-extended load result. Holds the core stalled while
// an access is in flight.
//
// Bus handshake: mem_req is raised in the cycle after an accepted start and
// held, together with mem_addr/mem_we/mem_wdata/mem_wstrb, until the first
// cycle in which mem_ack is sampled high (transfer complete, mem_rdata valid
// in that same cycle) or until MAX_WAIT cycles have passed without mem_ack.
// mem_ack outside an active request is ignored.
module lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] load_data,
  output logic        done,
  output logic [1:0]  fault,
  output logic        should_stall,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam logic [1:0] FAULT_OK        = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN  = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL   = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT   = 2'b11;
  localparam logic [7:0] MAX_WAIT_C      = 8'(MAX_WAIT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [7:0]  cnt_next;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;

  logic        accepted;
  logic        f3_legal;
  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_fmt;

  // Request decode: acceptance, funct3 legality and alignment of the new access
  always_comb begin
    accepted   = start && (is_load != is_store);
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    if (is_load) begin
      case (funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_legal = 1'b1;
        default:                      f3_legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'd0, 3'd1, 3'd2: f3_legal = 1'b1;
        default:          f3_legal = 1'b0;
      endcase
    end
    case (funct3[1:0])
      2'b01:   misaligned = address[0];
      2'b10:   misaligned = |address[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Store lane replication and byte enables for the new access
  always_comb begin
    st_wdata = store_data;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{store_data[7:0]}};
        st_wstrb = 4'b0001 << address[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data[15:0]}};
        st_wstrb = 4'b0011 << {address[1], 1'b0};
      end
      default: begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and extension from the latched lane/width
  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'd0:    ld_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    ld_fmt = {24'd0, rd_byte};
      3'd1:    ld_fmt = {{16{rd_half[15]}}, rd_half};
      3'd5:    ld_fmt = {16'd0, rd_half};
      default: ld_fmt = mem_rdata;
    endcase
  end

  assign cnt_next     = wait_cnt + 8'd1;
  assign should_stall = (state != IDLE) || accepted;
  assign state_dbg    = state;

  // Access sequencer: IDLE -> ACCESS -> DONE -> IDLE, or IDLE -> DONE on a fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      lane_q    <= 2'd0;
      f3_q      <= 3'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      load_data <= 32'd0;
      done      <= 1'b0;
      fault     <= FAULT_OK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accepted) begin
            if (!f3_legal) begin
              fault <= FAULT_ILLEGAL;
              done  <= 1'b1;
              state <= DONE;
            end else if (misaligned) begin
              fault <= FAULT_MISALIGN;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              fault     <= FAULT_OK;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {address[31:2], 2'b00};
              mem_wdata <= is_store ? st_wdata : 32'd0;
              mem_wstrb <= is_store ? st_wstrb : 4'd0;
              lane_q    <= address[1:0];
              f3_q      <= funct3;
              wait_cnt  <= 8'd0;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!mem_we) load_data <= ld_fmt;
            fault   <= FAULT_OK;
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (cnt_next == MAX_WAIT_C) begin
            wait_cnt <= cnt_next;
            fault    <= FAULT_TIMEOUT;
            mem_req  <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            wait_cnt <= cnt_next;
          end
        end
        DONE: begin
          wait_cnt <= 8'd0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed plus randomised bench for the load/store unit. Expected results
// ({fault, load_data}) are queued when an access is launched and compared
// when the unit reports completion.
module tb_lsu;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] load_data;
  logic        done;
  logic [1:0]  fault;
  logic        should_stall;
  logic [1:0]  state_dbg;

  int n_asserts;
  int n_fail;
  logic [33:0] exp_q[$];
  logic [31:0] last_ld;

  lsu #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_load      (is_load),
    .is_store     (is_store),
    .funct3       (funct3),
    .address      (address),
    .store_data   (store_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .load_data    (load_data),
    .done         (done),
    .fault        (fault),
    .should_stall (should_stall),
    .state_dbg    (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load formatting (shift the addressed lane to bit 0, then extend)
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * a);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  // Reference store lanes built byte by byte
  task automatic model_store(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d,
                             output logic [31:0] wdata, output logic [3:0] wstrb);
    int size;
    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int b = 0; b < 4; b++) begin
      wstrb[b] = (b >= int'(a)) && (b < int'(a) + size);
      wdata[8*b +: 8] = d[8*(b % size) +: 8];
    end
  endtask

  // Driver: launch one access and follow it to completion.
  // req_cycles = number of cycles mem_req must be high; done_cyc = 0 means no completion expected.
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rdata, input int ack_k,
                            input int req_cycles, input int done_cyc,
                            input logic [1:0] exp_fault, input logic [31:0] exp_ld,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_wstrb, input logic exp_we, input bit poke);
    bit got_done;
    int done_at;
    logic [33:0] e;
    if (done_cyc > 0) exp_q.push_back({exp_fault, exp_ld});
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; address = addr; store_data = data;
    #1;
    chk("stall_start", {31'd0, should_stall}, {31'd0, ld ^ st});
    @(posedge clk); #1;
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    got_done = 1'b0;
    done_at = 0;
    for (int c = 1; c <= 8 && !got_done; c++) begin
      chk("mem_req", {31'd0, mem_req}, {31'd0, c <= req_cycles});
      if (c <= req_cycles) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        chk("stall_busy", {31'd0, should_stall}, 32'd1);
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        done_at = c;
      end else begin
        if (c == ack_k) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
        if (poke && c == 2) begin
          start = 1'b1; is_store = 1'b1; is_load = 1'b0; funct3 = 3'd0;
          address = 32'hFFFF_FFF1; store_data = 32'h5555_5555;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
      end
    end
    chk("done_cycle", done_at, done_cyc);
    if (got_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("fault", {30'd0, fault}, {30'd0, e[33:32]});
        chk("load_data", load_data, e[31:0]);
      end
      @(posedge clk); #1;
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("fault_hold", {30'd0, fault}, {30'd0, exp_fault});
      chk("ld_hold", load_data, exp_ld);
      chk("idle", {30'd0, state_dbg}, 32'd0);
    end else if (exp_q.size() > 0 && done_cyc > 0) begin
      e = exp_q.pop_front();
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [31:0] base, d, rd, wd, exp_l;
    logic [3:0]  ws;
    int          k;
    bit          is_st;

    n_asserts = 0;
    n_fail = 0;
    last_ld = 32'd0;
    rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    address = 32'd0; store_data = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;

    // Reset state
    #7;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_fault", {30'd0, fault}, 32'd0);
    chk("rst_stall", {31'd0, should_stall}, 32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // LW, ack in first request cycle
    run_access(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1, 2, 2'b00, 32'hDEADBEEF,
               32'h100, 32'h0, 4'b0000, 1'b0, 0);
    // LB / LBU / LH sign and zero extension
    run_access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 2, 2, 3, 2'b00, 32'hFFFFFF80,
               32'h100, 32'h0, 4'b0000, 1'b0, 0);
    run_access(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 1, 1, 2, 2'b00, 32'h00000080,
               32'h100, 32'h0, 4'b0000, 1'b0, 0);
    run_access(1, 0, 3'd1, 32'h102, 32'h0, 32'h80FF1234, 1, 1, 2, 2'b00, 32'hFFFF80FF,
               32'h100, 32'h0, 4'b0000, 1'b0, 0);
    last_ld = 32'hFFFF80FF;
    // Stores: load_data must not move
    run_access(0, 1, 3'd0, 32'h201, 32'h000000AB, 32'h0, 1, 1, 2, 2'b00, last_ld,
               32'h200, 32'hABABABAB, 4'b0010, 1'b1, 0);
    run_access(0, 1, 3'd1, 32'h202, 32'h00001234, 32'h0, 2, 2, 3, 2'b00, last_ld,
               32'h200, 32'h12341234, 4'b1100, 1'b1, 0);
    run_access(0, 1, 3'd2, 32'h204, 32'hCAFEF00D, 32'h0, 1, 1, 2, 2'b00, last_ld,
               32'h204, 32'hCAFEF00D, 4'b1111, 1'b1, 0);
    // Faults: done in cycle 1, no request
    run_access(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 1, 0, 1, 2'b01, last_ld,
               32'h0, 32'h0, 4'b0000, 1'b0, 0);
    run_access(1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 1, 0, 1, 2'b10, last_ld,
               32'h0, 32'h0, 4'b0000, 1'b0, 0);
    run_access(0, 1, 3'd4, 32'h100, 32'h0, 32'h0, 1, 0, 1, 2'b10, last_ld,
               32'h0, 32'h0, 4'b0000, 1'b0, 0);
    run_access(0, 1, 3'd1, 32'h201, 32'h0, 32'h0, 1, 0, 1, 2'b01, last_ld,
               32'h0, 32'h0, 4'b0000, 1'b0, 0);
    // Ignored starts: both or neither type bit; fault stays 01
    run_access(1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 1, 0, 0, 2'b01, last_ld,
               32'h0, 32'h0, 4'b0000, 1'b0, 0);
    run_access(0, 0, 3'd2, 32'h100, 32'h0, 32'h0, 1, 0, 0, 2'b01, last_ld,
               32'h0, 32'h0, 4'b0000, 1'b0, 0);
    chk("ignored_fault_hold", {30'd0, fault}, 32'd1);
    // Timeout after MAX_WAIT cycles, then ack on the last allowed cycle
    run_access(1, 0, 3'd2, 32'h300, 32'h0, 32'h0, 0, 4, 5, 2'b11, last_ld,
               32'h300, 32'h0, 4'b0000, 1'b0, 0);
    run_access(1, 0, 3'd2, 32'h300, 32'h0, 32'h13579BDF, 4, 4, 5, 2'b00, 32'h13579BDF,
               32'h300, 32'h0, 4'b0000, 1'b0, 0);
    last_ld = 32'h13579BDF;
    // Start pulse while busy is ignored
    run_access(1, 0, 3'd2, 32'h400, 32'h0, 32'h2468ACE0, 3, 3, 4, 2'b00, 32'h2468ACE0,
               32'h400, 32'h0, 4'b0000, 1'b0, 1);
    last_ld = 32'h2468ACE0;

    // Reset during ACCESS drops the request immediately
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; address = 32'h500;
    @(posedge clk); #1;
    start = 1'b0; is_load = 1'b0;
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    chk("mid_rst_ld", load_data, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    last_ld = 32'd0;
    run_access(1, 0, 3'd2, 32'h504, 32'h0, 32'h0BADF00D, 1, 1, 2, 2'b00, 32'h0BADF00D,
               32'h504, 32'h0, 4'b0000, 1'b0, 0);
    last_ld = 32'h0BADF00D;

    // Random legal, aligned accesses
    for (int i = 0; i < 12; i++) begin
      is_st = ($urandom_range(0, 1) == 1);
      if (is_st) f3 = 3'($urandom_range(0, 2));
      else begin
        k = $urandom_range(0, 4);
        f3 = (k < 3) ? 3'(k) : 3'(k + 1);
      end
      case (f3[1:0])
        2'b00:   a = 2'($urandom_range(0, 3));
        2'b01:   a = {1'($urandom_range(0, 1)), 1'b0};
        default: a = 2'b00;
      endcase
      base = $urandom;
      base[1:0] = a;
      d = $urandom;
      rd = $urandom;
      k = $urandom_range(1, 3);
      if (is_st) begin
        model_store(f3, a, d, wd, ws);
        run_access(0, 1, f3, base, d, rd, k, k, k + 1, 2'b00, last_ld,
                   {base[31:2], 2'b00}, wd, ws, 1'b1, 0);
      end else begin
        exp_l = model_load(f3, a, rd);
        run_access(1, 0, f3, base, d, rd, k, k, k + 1, 2'b00, exp_l,
                   {base[31:2], 2'b00}, 32'h0, 4'b0000, 1'b0, 0);
        last_ld = exp_l;
      end
    end

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
